// File: rtl/branch_sched_pkg.sv
// Shared types for the predictor port scheduler: one queued resolved-branch update.
package branch_sched_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

endpackage

// File: rtl/branch_upd_queue.sv
// In-order FIFO of resolved-branch updates; count carries one extra bit so full and empty differ.
module branch_upd_queue
    import branch_sched_pkg::*;
#(
    parameter int unsigned p_depth = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enq,
    input  upd_entry_t i_enq_data,
    input  logic       i_deq,
    output logic       o_full,
    output logic       o_empty,
    output upd_entry_t o_head
);

    localparam int unsigned c_aw = $clog2(p_depth);

    upd_entry_t          r_mem [p_depth];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_aw:0]       r_count;
    logic                w_do_enq;
    logic                w_do_deq;

    assign o_full   = (r_count == (c_aw+1)'(p_depth));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign w_do_enq = i_enq && !o_full;
    assign w_do_deq = i_deq && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_enq && !reset) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_aw+1)'(w_do_enq) - (c_aw+1)'(w_do_deq);
        end
    end

endmodule

// File: rtl/branch_pht_port_sched.sv
// Arbitrates the GShare predictor's single PC port between fetch lookups and queued updates;
// fetch has priority, with a starvation counter forcing update progress.
module branch_pht_port_sched
    import branch_sched_pkg::*;
#(
    parameter int unsigned p_queue_depth = 4,
    parameter int unsigned p_max_starve  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_val,
    input  logic [31:0] fetch_req_pc,
    output logic        fetch_req_rdy,
    output logic        fetch_resp_val,
    output logic        fetch_resp_taken,
    input  logic        upd0_val,
    input  logic [31:0] upd0_pc,
    input  logic        upd0_taken,
    output logic        upd0_rdy,
    input  logic        upd1_val,
    input  logic [31:0] upd1_pc,
    input  logic        upd1_taken,
    output logic        upd1_rdy,
    output logic [31:0] pred_pc,
    output logic        pred_update_en,
    output logic        pred_update_val,
    input  logic        pred_prediction
);

    localparam int unsigned c_sw = $clog2(p_max_starve + 1);

    logic [c_sw-1:0] r_starve_cnt;
    logic            r_rr_ptr;
    logic            r_resp_val;
    logic            r_resp_taken;

    logic            w_full;
    logic            w_empty;
    upd_entry_t      w_head;
    upd_entry_t      w_enq_data;
    logic            w_starved;
    logic            w_upd_grant;
    logic            w_enq0;
    logic            w_enq1;
    logic            w_fetch_acc;

    branch_upd_queue #(.p_depth(p_queue_depth)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .i_enq      (w_enq0 || w_enq1),
        .i_enq_data (w_enq_data),
        .i_deq      (w_upd_grant),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    assign w_starved   = (r_starve_cnt == c_sw'(p_max_starve));
    assign w_upd_grant = !reset && !w_empty && (!fetch_req_val || w_full || w_starved);
    assign fetch_req_rdy = !reset && !w_upd_grant;
    assign w_fetch_acc = fetch_req_val && fetch_req_rdy;

    // A requester is ready when it holds the round-robin turn or the other side is idle.
    assign upd0_rdy = !reset && !w_full && (!r_rr_ptr || !upd1_val);
    assign upd1_rdy = !reset && !w_full && ( r_rr_ptr || !upd0_val);
    assign w_enq0   = upd0_val && upd0_rdy;
    assign w_enq1   = upd1_val && upd1_rdy;
    assign w_enq_data = w_enq0 ? upd_entry_t'{pc: upd0_pc, taken: upd0_taken}
                               : upd_entry_t'{pc: upd1_pc, taken: upd1_taken};

    always_comb begin
        pred_pc         = fetch_req_pc;
        pred_update_en  = 1'b0;
        pred_update_val = 1'b0;
        if (reset) begin
            pred_pc = '0;
        end else if (w_upd_grant) begin
            pred_pc         = w_head.pc;
            pred_update_en  = 1'b1;
            pred_update_val = w_head.taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_rr_ptr     <= 1'b0;
            r_resp_val   <= 1'b0;
            r_resp_taken <= 1'b0;
        end else begin
            r_resp_val <= w_fetch_acc;
            if (w_fetch_acc) r_resp_taken <= pred_prediction;
            if (w_enq0 || w_enq1) r_rr_ptr <= w_enq0;
            if (w_empty || w_upd_grant) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign fetch_resp_val   = r_resp_val;
    assign fetch_resp_taken = r_resp_taken;

endmodule

// File: tb/tb_branch_pht_port_sched.sv
// Directed bench for the predictor port scheduler: a vector table plus multi-cycle corner sequences.
module tb_branch_pht_port_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_val;
    logic [31:0] fetch_req_pc;
    logic        fetch_req_rdy;
    logic        fetch_resp_val;
    logic        fetch_resp_taken;
    logic        upd0_val;
    logic [31:0] upd0_pc;
    logic        upd0_taken;
    logic        upd0_rdy;
    logic        upd1_val;
    logic [31:0] upd1_pc;
    logic        upd1_taken;
    logic        upd1_rdy;
    logic [31:0] pred_pc;
    logic        pred_update_en;
    logic        pred_update_val;
    logic        pred_prediction;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] fpc;
        logic        u0v;
        logic [31:0] u0pc;
        logic        u0t;
        logic        u1v;
        logic [31:0] u1pc;
        logic        u1t;
        logic        pred;
        logic        eFrdy;
        logic        eU0rdy;
        logic        eU1rdy;
        logic        eEn;
        logic        eVal;
        logic [31:0] ePc;
        logic        eRv;
        logic        eRt;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    branch_pht_port_sched dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_req_val    (fetch_req_val),
        .fetch_req_pc     (fetch_req_pc),
        .fetch_req_rdy    (fetch_req_rdy),
        .fetch_resp_val   (fetch_resp_val),
        .fetch_resp_taken (fetch_resp_taken),
        .upd0_val         (upd0_val),
        .upd0_pc          (upd0_pc),
        .upd0_taken       (upd0_taken),
        .upd0_rdy         (upd0_rdy),
        .upd1_val         (upd1_val),
        .upd1_pc          (upd1_pc),
        .upd1_taken       (upd1_taken),
        .upd1_rdy         (upd1_rdy),
        .pred_pc          (pred_pc),
        .pred_update_en   (pred_update_en),
        .pred_update_val  (pred_update_val),
        .pred_prediction  (pred_prediction)
    );

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
    task automatic applyStimulus(input logic rst, input logic fv, input logic [31:0] fpc,
                                 input logic u0v, input logic [31:0] u0pc, input logic u0t,
                                 input logic u1v, input logic [31:0] u1pc, input logic u1t,
                                 input logic pred);
        @(posedge clk);
        #1;
        reset = rst; fetch_req_val = fv; fetch_req_pc = fpc;
        upd0_val = u0v; upd0_pc = u0pc; upd0_taken = u0t;
        upd1_val = u1v; upd1_pc = u1pc; upd1_taken = u1t;
        pred_prediction = pred;
        #3;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic checkPort(input string tag, input logic frdy, input logic en,
                             input logic val, input logic [31:0] pc);
        checkBit($sformatf("%s.fetch_rdy", tag), fetch_req_rdy, frdy);
        checkBit($sformatf("%s.upd_en", tag), pred_update_en, en);
        if (en) checkBit($sformatf("%s.upd_val", tag), pred_update_val, val);
        checkOutput($sformatf("%s.pred_pc", tag), pred_pc, pc);
    endtask

    task automatic idle(input logic rst);
        applyStimulus(rst, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // One update arrives under continuous fetch; it must wait p_max_starve cycles, then issue.
    task automatic starveSeq(input int id, input logic [31:0] pc, input logic tk);
        applyStimulus(1'b0, 1'b1, 32'h500, 1'b1, pc, tk, 1'b0, 32'h0, 1'b0, 1'b0);
        checkBit($sformatf("starve%0d.c0.u0rdy", id), upd0_rdy, 1'b1);
        checkPort($sformatf("starve%0d.c0", id), 1'b1, 1'b0, 1'b0, 32'h500);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkPort($sformatf("starve%0d.c%0d", id, c), 1'b1, 1'b0, 1'b0, 32'h500);
        end
        applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkPort($sformatf("starve%0d.c5", id), 1'b0, 1'b1, tk, pc);
    endtask

    initial begin
        // rst fv fpc | u0 | u1 | pred || frdy u0r u1r en val pc rv rt
        vecs[0]  = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h300, 1'b1, 32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h300, 1'b1, 32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h300, 1'b1, 32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB00, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h300, 1'b1, 32'h20C, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20C, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC04, 1'b0, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC04, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1};

        reset = 1'b1; fetch_req_val = 1'b0; fetch_req_pc = 32'h0;
        upd0_val = 1'b0; upd0_pc = 32'h0; upd0_taken = 1'b0;
        upd1_val = 1'b0; upd1_pc = 32'h0; upd1_taken = 1'b0;
        pred_prediction = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].fv, vecs[i].fpc, vecs[i].u0v, vecs[i].u0pc,
                          vecs[i].u0t, vecs[i].u1v, vecs[i].u1pc, vecs[i].u1t, vecs[i].pred);
            checkBit($sformatf("vec%0d.u0rdy", i), upd0_rdy, vecs[i].eU0rdy);
            checkBit($sformatf("vec%0d.u1rdy", i), upd1_rdy, vecs[i].eU1rdy);
            checkBit($sformatf("vec%0d.upd_val", i), pred_update_val, vecs[i].eVal);
            checkBit($sformatf("vec%0d.resp_val", i), fetch_resp_val, vecs[i].eRv);
            checkBit($sformatf("vec%0d.resp_taken", i), fetch_resp_taken, vecs[i].eRt);
            checkPort($sformatf("vec%0d", i), vecs[i].eFrdy, vecs[i].eEn, vecs[i].eVal, vecs[i].ePc);
        end

        starveSeq(0, 32'h50C, 1'b1);
        starveSeq(1, 32'h51C, 1'b0);

        // Fill the queue under continuous fetch; full forces a drain and blocks both requesters.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h600, 1'b1, 32'h610 + 32'(c) * 32'h10, (c % 2) == 0,
                          1'b0, 32'h0, 1'b0, 1'b0);
            checkBit($sformatf("fill.c%0d.u0rdy", c), upd0_rdy, 1'b1);
            checkPort($sformatf("fill.c%0d", c), 1'b1, 1'b0, 1'b0, 32'h600);
        end
        applyStimulus(1'b0, 1'b1, 32'h600, 1'b1, 32'h650, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkBit("fill.c4.u0rdy", upd0_rdy, 1'b0);
        checkBit("fill.c4.u1rdy", upd1_rdy, 1'b0);
        checkPort("fill.c4", 1'b0, 1'b1, 1'b1, 32'h610);
        applyStimulus(1'b0, 1'b1, 32'h600, 1'b1, 32'h650, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkBit("fill.c5.u0rdy", upd0_rdy, 1'b1);
        checkPort("fill.c5", 1'b1, 1'b0, 1'b0, 32'h600);
        for (int c = 0; c < 4; c++) begin
            idle(1'b0);
            checkPort($sformatf("drain.c%0d", c), 1'b0, 1'b1, (c % 2) == 1,
                      32'h620 + 32'(c) * 32'h10);
        end
        idle(1'b0);
        checkPort("drain.empty", 1'b1, 1'b0, 1'b0, 32'h300);

        // Reset while three updates are queued and a fetch response is pending.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h700, 1'b1, 32'h710 + 32'(c) * 32'h10, 1'b1,
                          1'b0, 32'h0, 1'b0, 1'b0);
            checkPort($sformatf("rst.c%0d", c), 1'b1, 1'b0, 1'b0, 32'h700);
        end
        applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkPort("rst.c3", 1'b1, 1'b0, 1'b0, 32'h700);
        applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 32'h740, 1'b1, 1'b1, 32'h750, 1'b1, 1'b0);
        checkBit("rst.c4.u0rdy", upd0_rdy, 1'b0);
        checkBit("rst.c4.u1rdy", upd1_rdy, 1'b0);
        checkBit("rst.c4.resp_val", fetch_resp_val, 1'b1);
        checkBit("rst.c4.resp_taken", fetch_resp_taken, 1'b1);
        checkPort("rst.c4", 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        checkBit("rst.c5.resp_val", fetch_resp_val, 1'b0);
        checkBit("rst.c5.resp_taken", fetch_resp_taken, 1'b0);
        checkPort("rst.c5", 1'b1, 1'b0, 1'b0, 32'h300);
        idle(1'b0);
        checkPort("rst.c6", 1'b1, 1'b0, 1'b0, 32'h300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
